dmem_arbiter: RTL and testbench

- Two-master arbiter in front of the single DMem port.
- Master 0 is the core load/store unit. Master 1 is the debug/loader port, used for image load and debugger memory access.
- Grants at most one request per cycle and drives DMem's request bus combinationally from the winner.
- Routes DMem's next-cycle load_data/addr_err back to the master that issued the request. Fully pipelined: one access per cycle.

---
 rtl/memory_pkg.sv | 26 ++
 rtl/dmem_arb_pick.sv | 36 +++
 rtl/dmem_arbiter.sv | 119 +++++++++++
 tb/tb_dmem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared memory-system types and constants: DMem geometry, load/store size
// encodings and the DMem arbiter's owner type.
package memory_pkg;

  localparam int unsigned MEM_ADDR_WIDTH = 32;
  localparam int unsigned MEM_WORD_WIDTH = 32;
  localparam logic [MEM_ADDR_WIDTH-1:0] START_ADDR = 32'h0000_1000;
  localparam int unsigned DMEM_SIZE = 256;

  typedef enum logic [1:0] {
    LS_SINGLE   = 2'd0,
    LS_HALFWORD = 2'd1,
    LS_WORD     = 2'd2
  } ls_size_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_M0,
    OWN_M1
  } dmem_owner_t;

  localparam int unsigned DMEM_MASTERS      = 2;
  localparam int unsigned DMEM_MAX_WAIT_DEF = 8;
  localparam int unsigned DMEM_WAIT_W       = 8;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select for the two DMem masters: fixed core priority
// with anti-starvation, or round-robin on the last grant.
module dmem_arb_pick
  import memory_pkg::*;
#(
  parameter int unsigned CORE_PRIO = 1,
  parameter int unsigned MAX_WAIT  = DMEM_MAX_WAIT_DEF
) (
  input  logic                   m0_req_i,
  input  logic                   m1_req_i,
  input  dmem_owner_t            last_gnt_i,
  input  logic [DMEM_WAIT_W-1:0] wait_cnt_i,
  output logic                   m0_win_o,
  output logic                   m1_win_o
);

  always_comb begin
    m0_win_o = 1'b0;
    m1_win_o = 1'b0;
    if (m0_req_i && m1_req_i) begin
      if (CORE_PRIO != 0) begin
        // m1 is forced through once it has been denied MAX_WAIT cycles in a row
        if (wait_cnt_i == DMEM_WAIT_W'(MAX_WAIT)) m1_win_o = 1'b1;
        else                                      m0_win_o = 1'b1;
      end else if (last_gnt_i == OWN_M0) begin
        m1_win_o = 1'b1;
      end else begin
        m0_win_o = 1'b1;
      end
    end else begin
      m0_win_o = m0_req_i;
      m1_win_o = m1_req_i;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of the single DMem port: grants one access per
// cycle and steers DMem's next-cycle response back to the issuing master.
module dmem_arbiter
  import memory_pkg::*;
#(
  parameter int unsigned ADDR_W    = MEM_ADDR_WIDTH,
  parameter int unsigned WORD_W    = MEM_WORD_WIDTH,
  parameter int unsigned CORE_PRIO = 1,
  parameter int unsigned MAX_WAIT  = DMEM_MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              m0_req,
  output logic              m0_gnt,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_write_en,
  input  logic              m0_l_unsigned,
  input  logic [1:0]        m0_n_bytes,
  input  logic [WORD_W-1:0] m0_store_data,
  output logic              m0_rvalid,
  output logic [WORD_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  output logic              m1_gnt,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_write_en,
  input  logic              m1_l_unsigned,
  input  logic [1:0]        m1_n_bytes,
  input  logic [WORD_W-1:0] m1_store_data,
  output logic              m1_rvalid,
  output logic [WORD_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              dmem_req,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_write_en,
  output logic              dmem_l_unsigned,
  output logic [1:0]        dmem_n_bytes,
  output logic [WORD_W-1:0] dmem_store_data,
  input  logic [WORD_W-1:0] dmem_load_data,
  input  logic              dmem_addr_err
);

  dmem_owner_t            rsp_owner_q, rsp_owner_d;
  dmem_owner_t            last_gnt_q, last_gnt_d;
  logic [DMEM_WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                   m0_win, m1_win;

  dmem_arb_pick #(
    .CORE_PRIO (CORE_PRIO),
    .MAX_WAIT  (MAX_WAIT)
  ) u_pick (
    .m0_req_i   (m0_req),
    .m1_req_i   (m1_req),
    .last_gnt_i (last_gnt_q),
    .wait_cnt_i (wait_cnt_q),
    .m0_win_o   (m0_win),
    .m1_win_o   (m1_win)
  );

  assign m0_gnt = m0_win;
  assign m1_gnt = m1_win;

  // Request bus follows the winner; idle cycles present m0's fields
  always_comb begin
    dmem_req        = m0_win | m1_win;
    dmem_addr       = m0_addr;
    dmem_write_en   = m0_write_en;
    dmem_l_unsigned = m0_l_unsigned;
    dmem_n_bytes    = m0_n_bytes;
    dmem_store_data = m0_store_data;
    if (m1_win) begin
      dmem_addr       = m1_addr;
      dmem_write_en   = m1_write_en;
      dmem_l_unsigned = m1_l_unsigned;
      dmem_n_bytes    = m1_n_bytes;
      dmem_store_data = m1_store_data;
    end
  end

  always_comb begin
    rsp_owner_d = OWN_NONE;
    last_gnt_d  = last_gnt_q;
    wait_cnt_d  = '0;
    if (m0_win) begin
      rsp_owner_d = OWN_M0;
      last_gnt_d  = OWN_M0;
    end else if (m1_win) begin
      rsp_owner_d = OWN_M1;
      last_gnt_d  = OWN_M1;
    end
    if (m1_req && !m1_win) begin
      wait_cnt_d = (wait_cnt_q == DMEM_WAIT_W'(MAX_WAIT)) ? wait_cnt_q
                                                          : wait_cnt_q + DMEM_WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_owner_q <= OWN_NONE;
      last_gnt_q  <= OWN_M1;
      wait_cnt_q  <= '0;
    end else begin
      rsp_owner_q <= rsp_owner_d;
      last_gnt_q  <= last_gnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  // DMem answers one cycle after the grant; only the recorded owner sees it
  always_comb begin
    m0_rvalid = (rsp_owner_q == OWN_M0);
    m1_rvalid = (rsp_owner_q == OWN_M1);
    m0_rdata  = m0_rvalid ? dmem_load_data : '0;
    m1_rdata  = m1_rvalid ? dmem_load_data : '0;
    m0_err    = m0_rvalid & dmem_addr_err;
    m1_err    = m1_rvalid & dmem_addr_err;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin instance and a core-priority
// (MAX_WAIT = 3) instance share master stimulus, each with its own DMem model.
module tb_dmem_arbiter;
  import memory_pkg::*;

  localparam int unsigned MW_CP = 3;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        m0_req, m0_we, m0_uns, m1_req, m1_we, m1_uns;
  logic [1:0]  m0_nb, m1_nb;
  logic [31:0] m0_addr, m0_sd, m1_addr, m1_sd;

  logic [1:0]  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [1:0]  dmem_req, dmem_we, dmem_uns, dmem_err;
  logic [31:0] m0_rdata [2];
  logic [31:0] m1_rdata [2];
  logic [31:0] dmem_addr [2];
  logic [31:0] dmem_sd [2];
  logic [31:0] dmem_ld [2];
  logic [1:0]  dmem_nb [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_arbiter #(
      .ADDR_W    (32),
      .WORD_W    (32),
      .CORE_PRIO ((g == 0) ? 0 : 1),
      .MAX_WAIT  ((g == 0) ? 8 : MW_CP)
    ) u_dut (
      .clk             (clk),
      .rstn            (rstn),
      .m0_req          (m0_req),
      .m0_gnt          (m0_gnt[g]),
      .m0_addr         (m0_addr),
      .m0_write_en     (m0_we),
      .m0_l_unsigned   (m0_uns),
      .m0_n_bytes      (m0_nb),
      .m0_store_data   (m0_sd),
      .m0_rvalid       (m0_rvalid[g]),
      .m0_rdata        (m0_rdata[g]),
      .m0_err          (m0_err[g]),
      .m1_req          (m1_req),
      .m1_gnt          (m1_gnt[g]),
      .m1_addr         (m1_addr),
      .m1_write_en     (m1_we),
      .m1_l_unsigned   (m1_uns),
      .m1_n_bytes      (m1_nb),
      .m1_store_data   (m1_sd),
      .m1_rvalid       (m1_rvalid[g]),
      .m1_rdata        (m1_rdata[g]),
      .m1_err          (m1_err[g]),
      .dmem_req        (dmem_req[g]),
      .dmem_addr       (dmem_addr[g]),
      .dmem_write_en   (dmem_we[g]),
      .dmem_l_unsigned (dmem_uns[g]),
      .dmem_n_bytes    (dmem_nb[g]),
      .dmem_store_data (dmem_sd[g]),
      .dmem_load_data  (dmem_ld[g]),
      .dmem_addr_err   (dmem_err[g])
    );
  end

  // ---------------- DMem model (one byte array per instance) ----------------
  logic [7:0] mem [2][256];

  function automatic logic [7:0] off(input logic [31:0] a);
    return 8'(a - START_ADDR);
  endfunction

  function automatic logic acc_ok(input logic [31:0] a, input logic [1:0] nb);
    logic [32:0] sz;
    if (nb == 2'd3) return 1'b0;
    sz = (nb == 2'd2) ? 33'd4 : (nb == 2'd1) ? 33'd2 : 33'd1;
    if (a < START_ADDR) return 1'b0;
    if ({1'b0, a} + sz > {1'b0, START_ADDR} + 33'(DMEM_SIZE)) return 1'b0;
    if (nb == 2'd1 && a[0]) return 1'b0;
    if (nb == 2'd2 && a[1:0] != 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] ld(input int k, input logic [31:0] a,
                                     input logic [1:0] nb, input logic u);
    logic [7:0] o;
    logic [7:0] b0, b1;
    o  = off(a);
    b0 = mem[k][o];
    b1 = mem[k][o + 8'd1];
    case (nb)
      2'd0:    return u ? {24'h0, b0} : {{24{b0[7]}}, b0};
      2'd1:    return u ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
      default: return {mem[k][o + 8'd3], mem[k][o + 8'd2], b1, b0};
    endcase
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (dmem_req[k] && acc_ok(dmem_addr[k], dmem_nb[k])) begin
        dmem_ld[k]  <= ld(k, dmem_addr[k], dmem_nb[k], dmem_uns[k]);
        dmem_err[k] <= 1'b0;
        if (dmem_we[k]) begin
          mem[k][off(dmem_addr[k])] <= dmem_sd[k][7:0];
          if (dmem_nb[k] != 2'd0) mem[k][off(dmem_addr[k]) + 8'd1] <= dmem_sd[k][15:8];
          if (dmem_nb[k] == 2'd2) begin
            mem[k][off(dmem_addr[k]) + 8'd2] <= dmem_sd[k][23:16];
            mem[k][off(dmem_addr[k]) + 8'd3] <= dmem_sd[k][31:24];
          end
        end
      end else begin
        dmem_ld[k]  <= '0;
        dmem_err[k] <= dmem_req[k];
      end
    end
  end

  // ---------------- checking ----------------
  int n_cmp;
  int n_err;
  int exp_own [2];   // -1 none, 0 = m0, 1 = m1
  int last [2];
  int wc [2];

  function automatic logic [31:0] b(input logic x);
    return {31'b0, x};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Whole-arbiter reference: who must win this cycle, what the bus and
  // response ports must show, then advance to the next edge's state.
  task automatic model_check();
    int w;
    logic [31:0] ea, es;
    logic ewe, eun;
    logic [1:0] enb;
    for (int k = 0; k < 2; k++) begin
      if (!rstn) begin
        exp_own[k] = -1;
        last[k]    = 1;
        wc[k]      = 0;
      end
      w = -1;
      if (rstn) begin
        if (m0_req && m1_req) begin
          if (k == 1) w = (wc[k] == int'(MW_CP)) ? 1 : 0;
          else        w = (last[k] == 0) ? 1 : 0;
        end else if (m0_req) w = 0;
        else if (m1_req)     w = 1;
      end
      ea  = (w == 1) ? m1_addr : m0_addr;
      es  = (w == 1) ? m1_sd   : m0_sd;
      ewe = (w == 1) ? m1_we   : m0_we;
      eun = (w == 1) ? m1_uns  : m0_uns;
      enb = (w == 1) ? m1_nb   : m0_nb;
      chk($sformatf("m0_gnt[%0d]", k), b(m0_gnt[k]), b(w == 0));
      chk($sformatf("m1_gnt[%0d]", k), b(m1_gnt[k]), b(w == 1));
      chk($sformatf("dmem_req[%0d]", k), b(dmem_req[k]), b(w >= 0));
      chk($sformatf("dmem_addr[%0d]", k), dmem_addr[k], ea);
      chk($sformatf("dmem_sd[%0d]", k), dmem_sd[k], es);
      chk($sformatf("dmem_ctl[%0d]", k), {28'h0, dmem_we[k], dmem_uns[k], dmem_nb[k]},
          {28'h0, ewe, eun, enb});
      chk($sformatf("m0_rvalid[%0d]", k), b(m0_rvalid[k]), b(exp_own[k] == 0));
      chk($sformatf("m1_rvalid[%0d]", k), b(m1_rvalid[k]), b(exp_own[k] == 1));
      chk($sformatf("m0_rdata[%0d]", k), m0_rdata[k], (exp_own[k] == 0) ? dmem_ld[k] : 32'h0);
      chk($sformatf("m1_rdata[%0d]", k), m1_rdata[k], (exp_own[k] == 1) ? dmem_ld[k] : 32'h0);
      chk($sformatf("m0_err[%0d]", k), b(m0_err[k]), b(exp_own[k] == 0 && dmem_err[k]));
      chk($sformatf("m1_err[%0d]", k), b(m1_err[k]), b(exp_own[k] == 1 && dmem_err[k]));
      if (rstn) begin
        exp_own[k] = w;
        if (w >= 0) last[k] = w;
        if (m1_req && w != 1) wc[k] = (wc[k] < int'(MW_CP)) ? wc[k] + 1 : wc[k];
        else                  wc[k] = 0;
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    model_check();
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    cyc();
    nxt();
  endtask

  task automatic set_m(input int m, input logic req, input logic we, input logic uns,
                       input logic [1:0] nb, input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_uns = uns; m0_nb = nb; m0_addr = a; m0_sd = d;
    end else begin
      m1_req = req; m1_we = we; m1_uns = uns; m1_nb = nb; m1_addr = a; m1_sd = d;
    end
  endtask

  task automatic idle();
    set_m(0, 1'b0, 1'b0, 1'b0, LS_WORD, 32'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 1'b0, LS_WORD, 32'h0, 32'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int k = 0; k < 2; k++) begin
      exp_own[k] = -1;
      last[k]    = 1;
      wc[k]      = 0;
    end
    rstn = 1'b0;
    idle();
    nxt();
    cyc();
    chk("rst_rvalid", {30'h0, m0_rvalid | m1_rvalid}, 32'h0);
    chk("rst_dmem_req", {30'h0, dmem_req}, 32'h0);
    nxt();
    rstn = 1'b1;
    step();

    // m0 SW then LW at +0x10
    set_m(0, 1'b1, 1'b1, 1'b0, LS_WORD, START_ADDR + 32'h10, 32'hDEAD_BEEF);
    cyc(); chk("t1_sw_gnt", {30'h0, m0_gnt}, 32'h3); nxt();
    set_m(0, 1'b1, 1'b0, 1'b0, LS_WORD, START_ADDR + 32'h10, 32'h0);
    cyc(); chk("t1_sw_rvalid", {30'h0, m0_rvalid}, 32'h3); nxt();
    idle();
    cyc();
    chk("t1_lw_rdata", m0_rdata[0], 32'hDEAD_BEEF);
    chk("t1_m1_quiet", {30'h0, m1_rvalid}, 32'h0);
    nxt();

    // preload +0x0 (m0) and +0x4 (m1); leaves last grant on m1
    set_m(0, 1'b1, 1'b1, 1'b0, LS_WORD, START_ADDR, 32'hCAFE_F00D);
    step();
    idle();
    set_m(1, 1'b1, 1'b1, 1'b0, LS_WORD, START_ADDR + 32'h4, 32'h1122_3344);
    step();
    idle();
    step();

    // both masters loading continuously
    set_m(0, 1'b1, 1'b0, 1'b0, LS_WORD, START_ADDR, 32'h0);
    set_m(1, 1'b1, 1'b0, 1'b0, LS_WORD, START_ADDR + 32'h4, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      cyc();
      if (c == 1) chk("t2_c1_m0_gnt", {30'h0, m0_gnt}, 32'h3);
      if (c == 2) begin
        chk("t2_rr_c2_m1_gnt", b(m1_gnt[0]), 32'h1);
        chk("t2_rr_c2_rdata", m0_rdata[0], 32'hCAFE_F00D);
      end
      if (c == 3) begin
        chk("t2_rr_c3_rdata", m1_rdata[0], 32'h1122_3344);
        chk("t2_cp_c3_m1_gnt", b(m1_gnt[1]), 32'h0);
      end
      if (c == 4) chk("t2_cp_c4_m1_gnt", b(m1_gnt[1]), 32'h1);
      if (c == 5) chk("t2_cp_c5_rdata", m1_rdata[1], 32'h1122_3344);
      if (c == 8) chk("t2_cp_c8_m1_gnt", b(m1_gnt[1]), 32'h1);
      nxt();
    end
    idle();
    step();

    // m1 drops its request after two denials: its wait count starts over
    for (int c = 1; c <= 7; c++) begin
      set_m(0, 1'b1, 1'b0, 1'b0, LS_WORD, START_ADDR, 32'h0);
      set_m(1, c != 3, 1'b0, 1'b0, LS_WORD, START_ADDR + 32'h4, 32'h0);
      cyc();
      if (c == 6) chk("t3_cp_c6_m1_gnt", b(m1_gnt[1]), 32'h0);
      if (c == 7) chk("t3_cp_c7_m1_gnt", b(m1_gnt[1]), 32'h1);
      nxt();
    end
    idle();
    step();

    // m1 SB 0x80 at +0x13, then LB and LBU
    set_m(1, 1'b1, 1'b1, 1'b0, LS_SINGLE, START_ADDR + 32'h13, 32'h0000_0080);
    step();
    set_m(1, 1'b1, 1'b0, 1'b0, LS_SINGLE, START_ADDR + 32'h13, 32'h0);
    step();
    set_m(1, 1'b1, 1'b0, 1'b1, LS_SINGLE, START_ADDR + 32'h13, 32'h0);
    cyc();
    chk("t4_lb_rr", m1_rdata[0], 32'hFFFF_FF80);
    chk("t4_lb_cp", m1_rdata[1], 32'hFFFF_FF80);
    nxt();
    idle();
    cyc();
    chk("t4_lbu_rr", m1_rdata[0], 32'h0000_0080);
    chk("t4_lbu_cp", m1_rdata[1], 32'h0000_0080);
    nxt();

    // out-of-range load from m0, then a normal m1 load
    set_m(0, 1'b1, 1'b0, 1'b0, LS_WORD, START_ADDR + 32'(DMEM_SIZE), 32'h0);
    step();
    idle();
    set_m(1, 1'b1, 1'b0, 1'b0, LS_WORD, START_ADDR + 32'h4, 32'h0);
    cyc();
    chk("t5_err_rvalid", {30'h0, m0_rvalid}, 32'h3);
    chk("t5_err", {30'h0, m0_err}, 32'h3);
    chk("t5_m1_gnt", {30'h0, m1_gnt}, 32'h3);
    nxt();
    idle();
    cyc();
    chk("t5_m1_err", {30'h0, m1_err}, 32'h0);
    chk("t5_m1_rdata", m1_rdata[0], 32'h1122_3344);
    nxt();

    // reset between a grant and its response
    set_m(0, 1'b1, 1'b0, 1'b0, LS_WORD, START_ADDR, 32'h0);
    step();
    rstn = 1'b0;
    idle();
    cyc(); chk("t6_no_rvalid", {30'h0, m0_rvalid}, 32'h0); nxt();
    step();
    rstn = 1'b1;
    set_m(0, 1'b1, 1'b0, 1'b0, LS_WORD, START_ADDR, 32'h0);
    set_m(1, 1'b1, 1'b0, 1'b0, LS_WORD, START_ADDR + 32'h4, 32'h0);
    cyc();
    chk("t6_rr_m0_first", b(m0_gnt[0]), 32'h1);
    chk("t6_post_rvalid", {30'h0, m0_rvalid | m1_rvalid}, 32'h0);
    nxt();
    idle();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
